// File: rtl/comp_sar_search.sv
// Successive-approximation search that recovers the comparator's unknown a operand
// by driving trial values on guess and reading back eq/gt/lt, MSB first.
module comp_sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] TRIAL = 1'b1;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);

  logic [0:0]       state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic             busy_n, done_n, err_n;

  logic [WIDTH-1:0] bit_cur, bit_low;
  logic             one_hot, last, finish;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= IDX_TOP;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      guess  <= guess_n;
      busy   <= busy_n;
      done   <= done_n;
      result <= result_n;
      err    <= err_n;
    end
  end

  // Next-state and output decision; one comparator evaluation per TRIAL cycle
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    guess_n  = guess;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    err_n    = err;
    finish   = 1'b0;

    bit_cur  = WIDTH'(1) << idx;
    bit_low  = bit_cur >> 1;
    // Odd flag count minus the all-three case leaves exactly-one-high
    one_hot  = (cmp_eq ^ cmp_gt ^ cmp_lt) & ~(cmp_eq & cmp_gt & cmp_lt);
    last     = (idx == '0);

    case (state)
      IDLE: begin
        if (start) begin
          guess_n = MSB_ONLY;
          idx_n   = IDX_TOP;
          busy_n  = 1'b1;
          err_n   = 1'b0;
          state_n = TRIAL;
        end
      end
      TRIAL: begin
        if (!one_hot) begin
          result_n = guess;
          err_n    = 1'b1;
          finish   = 1'b1;
        end else if (cmp_eq) begin
          result_n = guess;
          finish   = 1'b1;
        end else if (cmp_gt) begin
          if (last) begin
            result_n = guess;
            err_n    = 1'b1;
            finish   = 1'b1;
          end else begin
            guess_n = guess | bit_low;
            idx_n   = idx - IW'(1);
          end
        end else begin
          if (last) begin
            result_n = guess & ~bit_cur;
            finish   = 1'b1;
          end else begin
            guess_n = (guess & ~bit_cur) | bit_low;
            idx_n   = idx - IW'(1);
          end
        end

        if (finish) begin
          guess_n = result_n;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_comp_sar_search.sv
// Directed bench for comp_sar_search with a behavioural 4-bit comparator in the loop
// and an override path for injecting inconsistent flags.
module tb_comp_sar_search;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmp_eq, cmp_gt, cmp_lt;
  logic [3:0] guess, result;
  logic       busy, done, err;

  logic [3:0] target = 4'h0;
  logic       force_en = 1'b0;
  logic       f_eq = 1'b0, f_gt = 1'b0, f_lt = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Comparator: a = target, b = guess
  assign cmp_eq = force_en ? f_eq : (target == guess);
  assign cmp_gt = force_en ? f_gt : (target >  guess);
  assign cmp_lt = force_en ? f_lt : (target <  guess);

  comp_sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one search; seq holds the expected guesses MSB-nibble first when exp_trials > 0,
  // exp_trials == 0 only bounds the trial count. pulse_at re-asserts start on that trial.
  task automatic do_search(input string tag, input logic [3:0] tgt, input logic [3:0] exp_res,
                           input logic exp_err, input int exp_trials, input logic [15:0] seq,
                           input int pulse_at);
    int n;
    logic [3:0] e;
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 8) begin
      if (exp_trials > 0 && n < 4) begin
        e = 4'(seq >> (12 - 4 * n));
        chk({tag, "_guess"}, 32'(guess), 32'(e));
      end
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      start = (n == pulse_at);
      tick();
      start = 1'b0;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'(exp_res));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_guess_final"}, 32'(guess), 32'(exp_res));
    if (exp_trials > 0) chk({tag, "_trials"}, 32'(n), 32'(exp_trials));
    else                chk({tag, "_trials_le4"}, 32'(n <= 4), 32'd1);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_result_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    #12;
    chk("reset_guess", 32'(guess), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_hold_busy", 32'(busy), 32'd0);

    do_search("a0", 4'h0, 4'h0, 1'b0, 4, 16'h8421, -1);
    do_search("aF", 4'hF, 4'hF, 1'b0, 4, 16'h8CEF, -1);
    do_search("a8", 4'h8, 4'h8, 1'b0, 1, 16'h8000, -1);
    do_search("a5", 4'h5, 4'h5, 1'b0, 4, 16'h8465, -1);
    do_search("aA", 4'hA, 4'hA, 1'b0, 3, 16'h8CA0, -1);

    // Abort: reset lands after the 2nd trial decision of a=9
    target = 4'h9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick();
    chk("abort_guess_t2", 32'(guess), 32'hC);
    tick();
    chk("abort_guess_t3", 32'(guess), 32'hA);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_guess", 32'(guess), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    do_search("a9_after_abort", 4'h9, 4'h9, 1'b0, 4, 16'h8CA9, -1);

    // Inconsistent flags on the 2nd trial
    target = 4'hA;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("inj_guess_t1", 32'(guess), 32'h8);
    tick();
    chk("inj_guess_t2", 32'(guess), 32'hC);
    force_en = 1'b1;
    f_eq = 1'b1;
    f_gt = 1'b1;
    f_lt = 1'b0;
    tick();
    force_en = 1'b0;
    chk("inj_done", 32'(done), 32'd1);
    chk("inj_busy", 32'(busy), 32'd0);
    chk("inj_err", 32'(err), 32'd1);
    chk("inj_result", 32'(result), 32'hC);
    tick();
    chk("inj_done_pulse", 32'(done), 32'd0);
    chk("inj_err_held", 32'(err), 32'd1);

    // Start re-pulsed during the a=3 search must be ignored; also clears err from above
    do_search("a3_busy_start", 4'h3, 4'h3, 1'b0, 4, 16'h8423, 1);
    tick();
    chk("a3_no_restart", 32'(busy), 32'd0);

    for (int v = 0; v < 16; v++) begin
      do_search("exh", 4'(v), 4'(v), 1'b0, 0, 16'h0000, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
